step_pulse_controller: RTL

- Upstream stage between a raw board push button and the processor's step-clock input.
- Synchronizes and debounces the active-low button and emits exactly one single-cycle step pulse per press.
- Optionally auto-repeats pulses while the button is held.
- Keeps a wrapping count of issued pulses for hex-display debug.

---
 rtl/step_pulse_controller.sv | 120 ++++++++++++
 1 files changed

// File: rtl/step_pulse_controller.sv
// Push-button front end for the processor step clock: synchronizes and debounces
// an active-low button, issues one step strobe per press, optionally auto-repeats.
module step_pulse_controller #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int DB_W            = 20,
  parameter int REPEAT_CYCLES   = 13500000,
  parameter int RPT_W           = 24
) (
  input  logic        clk_27,
  input  logic        reset,
  input  logic        pb_n,
  input  logic        run_mode,
  output logic        pb_state,
  output logic        step_pulse,
  output logic [15:0] step_count,
  output logic        held
);

  localparam logic [0:0]       S_IDLE   = 1'b0;
  localparam logic [0:0]       S_HELD   = 1'b1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

  logic              r_sync_1;
  logic              r_sync_2;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_pb_state;
  logic [0:0]        r_state;
  logic [RPT_W-1:0]  r_rpt_cnt;
  logic              r_step_pulse;
  logic [15:0]       r_step_count;

  logic              w_lvl;
  logic [0:0]        w_state_next;
  logic [RPT_W-1:0]  w_rpt_next;
  logic              w_pulse_next;

  assign w_lvl = ~r_sync_2;

  // Sync flops reset to the released level so a held button is re-debounced after reset.
  always_ff @(posedge clk_27 or posedge reset) begin
    if (reset) begin
      r_sync_1 <= 1'b1;
      r_sync_2 <= 1'b1;
    end else begin
      r_sync_1 <= pb_n;
      r_sync_2 <= r_sync_1;
    end
  end

  always_ff @(posedge clk_27 or posedge reset) begin
    if (reset) begin
      r_db_cnt   <= '0;
      r_pb_state <= 1'b0;
    end else if (w_lvl == r_pb_state) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_pb_state <= w_lvl;
      r_db_cnt   <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_ONE;
    end
  end

  // Release is tested first in HELD so it beats a coincident repeat terminal count.
  always_comb begin
    w_state_next = r_state;
    w_rpt_next   = r_rpt_cnt;
    w_pulse_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pb_state) begin
          w_state_next = S_HELD;
          w_pulse_next = 1'b1;
          w_rpt_next   = '0;
        end
      end
      S_HELD: begin
        if (!r_pb_state) begin
          w_state_next = S_IDLE;
          w_rpt_next   = '0;
        end else if (!run_mode) begin
          w_rpt_next = '0;
        end else if (r_rpt_cnt == RPT_LAST) begin
          w_pulse_next = 1'b1;
          w_rpt_next   = '0;
        end else begin
          w_rpt_next = r_rpt_cnt + RPT_ONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_rpt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_27 or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rpt_cnt    <= '0;
      r_step_pulse <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_rpt_cnt    <= w_rpt_next;
      r_step_pulse <= w_pulse_next;
      if (w_pulse_next)
        r_step_count <= r_step_count + 16'd1;
    end
  end

  assign pb_state   = r_pb_state;
  assign step_pulse = r_step_pulse;
  assign step_count = r_step_count;
  assign held       = (r_state == S_HELD);

endmodule
